// File: rtl/vga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pkg: 800x600@60 timing constants, capture FSM states and counter helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int CNT_W = 11;
    localparam int RGB_W = 12;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RGB_W-1:0] rgb_t;

    localparam int VGA_H_TOTAL  = 1056;
    localparam int VGA_H_SYNC   = 128;
    localparam int VGA_H_BP     = 88;
    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_V_TOTAL  = 628;
    localparam int VGA_V_SYNC   = 4;
    localparam int VGA_V_BP     = 23;
    localparam int VGA_V_ACTIVE = 600;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Counters stick at all-ones so a missing sync can never alias a valid length.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == {CNT_W{1'b1}}) ? v : v + cnt_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_capture_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_capture_if: raw VGA input side plus captured pixel/status output side.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface vga_capture_if;
    import vga_pkg::*;

    logic hs_in;
    logic vs_in;
    rgb_t rgb_in;
    logic de;
    cnt_t x;
    cnt_t y;
    rgb_t rgb_out;
    logic sof;
    logic locked;
    logic sync_err;

    modport master (
        output hs_in, vs_in, rgb_in,
        input  de, x, y, rgb_out, sof, locked, sync_err
    );

    modport slave (
        input  hs_in, vs_in, rgb_in,
        output de, x, y, rgb_out, sof, locked, sync_err
    );

endinterface
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_edge: two-flop register of an incoming sync and its rising-edge pulse.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sync_edge (
    input  wire logic pclk,
    input  wire logic rst_n,
    input  wire logic din,
    output logic      rise
);

    logic sync_r;
    logic sync_rr;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= 1'b0;
            sync_rr <= 1'b0;
        end else begin
            sync_r  <= din;
            sync_rr <= sync_r;
        end
    end

    assign rise = sync_r & ~sync_rr;

endmodule
`default_nettype wire

// File: rtl/vga_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_capture: locks to a VGA source matching the timing parameters and emits
// visible pixels with coordinates two cycles after the inputs. Revision: 1.0
// ---------------------------------------------------------------------------
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES = 2
) (
    input  wire logic    pclk,
    input  wire logic    rst_n,
    vga_capture_if.slave bus
);

    localparam int GW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    typedef logic [GW-1:0] gcnt_t;

    localparam cnt_t  H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t  V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t  H_START = cnt_t'(H_SYNC + H_BP);
    localparam cnt_t  H_END   = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
    localparam cnt_t  V_START = cnt_t'(V_SYNC + V_BP);
    localparam cnt_t  V_END   = cnt_t'(V_SYNC + V_BP + V_ACTIVE);
    localparam gcnt_t LOCK_N  = gcnt_t'(LOCK_FRAMES);

    // Stage 1: registered syncs and pixel data
    logic hs_rise;
    logic vs_rise;
    rgb_t rgb_r;

    sync_edge u_hs_edge (
        .pclk  (pclk),
        .rst_n (rst_n),
        .din   (bus.hs_in),
        .rise  (hs_rise)
    );

    sync_edge u_vs_edge (
        .pclk  (pclk),
        .rst_n (rst_n),
        .din   (bus.vs_in),
        .rise  (vs_rise)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r <= '0;
        end else begin
            rgb_r <= bus.rgb_in;
        end
    end

    // Timing tracking and lock FSM
    cnt_t       hcnt;
    cnt_t       vcnt;
    cnt_t       hcnt_nxt;
    cnt_t       vcnt_nxt;
    logic       vs_pend;
    logic       first_edge;
    logic [1:0] state;
    logic [1:0] state_nxt;
    gcnt_t      good_cnt;
    gcnt_t      good_cnt_nxt;
    logic       line_bad;
    logic       frame_good;
    logic       err_nxt;

    // Output-stage next values
    logic h_win;
    logic v_win;
    logic de_nxt;
    cnt_t x_nxt;
    cnt_t y_nxt;
    rgb_t rgb_nxt;
    logic sof_nxt;

    always_comb begin
        hcnt_nxt = hs_rise ? '0 : sat_inc(hcnt);
        vcnt_nxt = vcnt;
        if (hs_rise) begin
            vcnt_nxt = (vs_pend || vs_rise) ? '0 : sat_inc(vcnt);
        end

        // Line is judged before the frame when both edges coincide; any bad line
        // already leaves CHECK/LOCKED, so surviving frames consist of good lines.
        line_bad   = hs_rise && !first_edge && (hcnt != H_LAST);
        frame_good = (vcnt == V_LAST);

        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        err_nxt      = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (vs_rise) begin
                    state_nxt    = ST_CHECK;
                    good_cnt_nxt = '0;
                end
            end
            ST_CHECK: begin
                if (line_bad) begin
                    state_nxt = ST_SEARCH;
                end else if (vs_rise) begin
                    if (!frame_good) begin
                        state_nxt = ST_SEARCH;
                    end else begin
                        good_cnt_nxt = good_cnt + gcnt_t'(1);
                        if (good_cnt_nxt == LOCK_N) begin
                            state_nxt = ST_LOCKED;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (line_bad || (vs_rise && !frame_good)) begin
                    state_nxt = ST_SEARCH;
                    err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_SEARCH;
            end
        endcase

        h_win   = (hcnt_nxt >= H_START) && (hcnt_nxt < H_END);
        v_win   = (vcnt_nxt >= V_START) && (vcnt_nxt < V_END);
        de_nxt  = (state_nxt == ST_LOCKED) && h_win && v_win;
        x_nxt   = de_nxt ? (hcnt_nxt - H_START) : '0;
        y_nxt   = de_nxt ? (vcnt_nxt - V_START) : '0;
        rgb_nxt = de_nxt ? rgb_r : '0;
        sof_nxt = de_nxt && (x_nxt == '0) && (y_nxt == '0);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt       <= '0;
            vcnt       <= '0;
            vs_pend    <= 1'b0;
            first_edge <= 1'b1;
            state      <= ST_SEARCH;
            good_cnt   <= '0;
        end else begin
            hcnt     <= hcnt_nxt;
            vcnt     <= vcnt_nxt;
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
            if (hs_rise) begin
                vs_pend <= 1'b0;
            end else if (vs_rise) begin
                vs_pend <= 1'b1;
            end
            if ((state_nxt == ST_SEARCH) && (state != ST_SEARCH)) begin
                first_edge <= 1'b1;
            end else if (hs_rise) begin
                first_edge <= 1'b0;
            end
        end
    end

    // Stage 2: registered outputs
    logic de_q;
    cnt_t x_q;
    cnt_t y_q;
    rgb_t rgb_q;
    logic sof_q;
    logic locked_q;
    logic err_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            rgb_q    <= '0;
            sof_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            de_q     <= de_nxt;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            rgb_q    <= rgb_nxt;
            sof_q    <= sof_nxt;
            locked_q <= (state_nxt == ST_LOCKED);
            err_q    <= err_nxt;
        end
    end

    assign bus.de       = de_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.rgb_out  = rgb_q;
    assign bus.sof      = sof_q;
    assign bus.locked   = locked_q;
    assign bus.sync_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_capture: directed bench on a scaled 16-cycle x 10-line timing.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vga_capture;

    localparam int HT = 16, HS = 2, HB = 2, HA = 10;
    localparam int VT = 10, VS = 1, VB = 2, VA = 5;
    localparam int HX0 = HS + HB;
    localparam int VY0 = VS + VB;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;

    always #5 pclk = ~pclk;

    vga_capture_if bus ();

    vga_capture #(
        .H_TOTAL     (HT),
        .H_SYNC      (HS),
        .H_BP        (HB),
        .H_ACTIVE    (HA),
        .V_TOTAL     (VT),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .V_ACTIVE    (VA),
        .LOCK_FRAMES (2)
    ) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cycles, de_cnt, sof_cnt, err_cnt, pix_bad, err_cyc, rise_cyc, fall_cyc;
    int   prev_l = 99;
    int   prev_p = 99;
    logic locked_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit vis(input int l, input int p);
        return (l >= VY0) && (l < VY0 + VA) && (p >= HX0) && (p < HX0 + HA);
    endfunction

    task automatic clear_stats();
        cycles   = 0;
        de_cnt   = 0;
        sof_cnt  = 0;
        err_cnt  = 0;
        pix_bad  = 0;
        err_cyc  = -1;
        rise_cyc = -1;
        fall_cyc = -1;
        locked_q = bus.locked;
    endtask

    // Outputs seen now belong to the pixel driven one call earlier (prev_l/prev_p).
    task automatic sample();
        logic [11:0] exp_rgb;
        exp_rgb = {4'(prev_p - HX0), 4'(prev_l - VY0), 4'h5};
        cycles++;
        if (bus.sync_err) begin
            err_cnt++;
            if (err_cyc < 0) err_cyc = cycles;
        end
        if (bus.sof) sof_cnt++;
        if (bus.de) begin
            de_cnt++;
            if (!vis(prev_l, prev_p) || (int'(bus.x) != prev_p - HX0) ||
                (int'(bus.y) != prev_l - VY0) || (bus.rgb_out != exp_rgb))
                pix_bad++;
            if (bus.sof != ((prev_p == HX0) && (prev_l == VY0))) pix_bad++;
        end else if ((bus.x != 0) || (bus.y != 0) || (bus.rgb_out != 0) || bus.sof) begin
            pix_bad++;
        end
        if (bus.locked && !locked_q && (rise_cyc < 0)) rise_cyc = cycles;
        if (!bus.locked && locked_q && (fall_cyc < 0)) fall_cyc = cycles;
        locked_q = bus.locked;
    endtask

    task automatic cyc(input logic hs, input logic vs, input int l, input int p);
        bus.hs_in  = hs;
        bus.vs_in  = vs;
        bus.rgb_in = vis(l, p) ? {4'(p - HX0), 4'(l - VY0), 4'h5} : 12'hABC;
        @(posedge pclk);
        #1;
        sample();
        prev_l = l;
        prev_p = p;
    endtask

    task automatic drive_line(input int l, input int len);
        for (int p = 0; p < len; p++) cyc(p < HS, l < VS, l, p);
    endtask

    task automatic drive_frame(input int short_l);
        for (int l = 0; l < VT; l++) drive_line(l, (l == short_l) ? HT - 1 : HT);
    endtask

    initial begin
        bus.hs_in  = 1'b0;
        bus.vs_in  = 1'b0;
        bus.rgb_in = 12'h000;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_de",       bus.de,       0);
        chk("rst_x",        bus.x,        0);
        chk("rst_y",        bus.y,        0);
        chk("rst_rgb",      bus.rgb_out,  0);
        chk("rst_sof",      bus.sof,      0);
        chk("rst_locked",   bus.locked,   0);
        chk("rst_sync_err", bus.sync_err, 0);
        @(negedge pclk) rst_n = 1'b1;

        // Acquire from reset: lock after the third vsync edge
        clear_stats();
        for (int f = 0; f < 4; f++) drive_frame(-1);
        chk("a_lock_cyc", rise_cyc, 322);
        chk("a_errs",     err_cnt,  0);
        chk("a_de",       de_cnt,   100);
        chk("a_sof",      sof_cnt,  2);
        chk("a_pix",      pix_bad,  0);
        chk("a_locked",   bus.locked, 1);

        // One 15-cycle line while locked
        clear_stats();
        drive_frame(5);
        for (int f = 0; f < 3; f++) drive_frame(-1);
        chk("b_errs",     err_cnt,  1);
        chk("b_err_cyc",  err_cyc,  97);
        chk("b_fall_cyc", fall_cyc, 97);
        chk("b_lock_cyc", rise_cyc, 481);
        chk("b_de",       de_cnt,   80);
        chk("b_sof",      sof_cnt,  2);
        chk("b_pix",      pix_bad,  0);

        // hsync stops long enough to saturate, then resumes with coincident edges
        clear_stats();
        for (int l = 0; l < 4; l++) drive_line(l, HT);
        repeat (2100) cyc(1'b0, 1'b0, 99, 99);
        chk("c_gap_de",     de_cnt,     10);
        chk("c_gap_errs",   err_cnt,    0);
        chk("c_gap_locked", bus.locked, 1);
        for (int f = 0; f < 4; f++) drive_frame(-1);
        chk("c_errs",     err_cnt,  1);
        chk("c_err_cyc",  err_cyc,  2166);
        chk("c_fall_cyc", fall_cyc, 2166);
        chk("c_lock_cyc", rise_cyc, 2646);
        chk("c_de",       de_cnt,   60);
        chk("c_sof",      sof_cnt,  2);
        chk("c_pix",      pix_bad,  0);

        // Asynchronous reset in the middle of a visible line
        clear_stats();
        for (int l = 0; l < 4; l++) drive_line(l, HT);
        for (int p = 0; p < 8; p++) cyc(p < HS, 1'b0, 4, p);
        chk("d_de_before", bus.de, 1);
        chk("d_x_before",  bus.x,  2);
        #2 rst_n = 1'b0;
        #1;
        chk("d_async_de",     bus.de,       0);
        chk("d_async_xy",     {bus.x, bus.y}, 0);
        chk("d_async_rgb",    bus.rgb_out,  0);
        chk("d_async_locked", bus.locked,   0);
        chk("d_async_flags",  {bus.sof, bus.sync_err}, 0);
        repeat (3) @(posedge pclk);
        bus.hs_in = 1'b0;
        bus.vs_in = 1'b0;
        @(negedge pclk) rst_n = 1'b1;
        prev_l = 99;
        prev_p = 99;
        clear_stats();
        for (int f = 0; f < 4; f++) drive_frame(-1);
        chk("d_lock_cyc", rise_cyc, 322);
        chk("d_errs",     err_cnt,  0);
        chk("d_de",       de_cnt,   100);
        chk("d_sof",      sof_cnt,  2);
        chk("d_pix",      pix_bad,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_TOTAL, default 1056, meaning pclk cycles per line.
REQ-002 Parameter H_SYNC, default 128, meaning hsync pulse width in cycles.
REQ-003 Parameter H_BP, default 88, meaning horizontal back porch in cycles.
REQ-004 Parameter H_ACTIVE, default 800, meaning visible pixels per line.
REQ-005 Parameter V_TOTAL, default 628, meaning lines per frame.
REQ-006 Parameter V_SYNC, default 4, meaning vsync width in lines.
REQ-007 Parameter V_BP, default 23, meaning vertical back porch in lines.
REQ-008 Parameter V_ACTIVE, default 600, meaning visible lines.
REQ-009 Parameter LOCK_FRAMES, default 2, meaning consecutive good frames required for lock.
REQ-010 Port pclk, input, 1, meaning single clock; all logic is on its rising edge.
REQ-011 Port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-012 Port hs_in, vs_in, input, 1 each, meaning active-high syncs from the VGA source.
REQ-013 Port rgb_in, input, 12, meaning {r,g,b}, 4 bits each.
REQ-014 Port de, output, 1, meaning a visible pixel is present on x/y/rgb_out.
REQ-015 Port x, y, output, 11 each, meaning visible pixel coordinates, with 0,0 at top-left.
REQ-016 Port rgb_out, output, 12, meaning the captured pixel.
REQ-017 Port sof, output, 1, meaning a one-cycle pulse with the first de pixel (0,0) of a frame.
REQ-018 Port locked, output, 1, meaning timing matches the parameters.
REQ-019 Port sync_err, output, 1, meaning a one-cycle pulse on detection of a timing mismatch.

Function
REQ-020 Inputs hs_in, vs_in and rgb_in SHALL be registered once (stage 1) before use, and all outputs SHALL be registered (stage 2), giving a fixed input-to-output latency of 2 cycles.
REQ-021 The block SHALL detect the hsync rising edge as hs_r=1 with hs_rr=0, and the vsync rising edge likewise.
REQ-022 hcnt (11 bits) SHALL load 0 on the hsync rising edge and otherwise increment, saturating at 2047.
REQ-023 vcnt (11 bits) SHALL load 0 on the first hsync edge at or after a vsync rising edge, and otherwise increment on each hsync edge, saturating.
REQ-024 On an hsync edge, a line is good when the prior hcnt equals H_TOTAL-1, and bad otherwise; the first edge after SEARCH entry is exempt.
REQ-025 On a vsync edge, a frame is good when the prior vcnt equals V_TOTAL-1 and every line in it was good.
REQ-026 The FSM SHALL have three states: SEARCH, which waits for a vsync edge, then moves to CHECK with good_cnt cleared.
REQ-027 In CHECK, a good frame SHALL increment good_cnt; when good_cnt reaches LOCK_FRAMES the FSM SHALL move to LOCKED; a bad line or frame SHALL move to SEARCH.
REQ-028 In LOCKED, a bad line or frame SHALL pulse sync_err, move to SEARCH and clear locked in the same cycle.
REQ-029 locked SHALL be 1 exactly while the state is LOCKED.
REQ-030 de SHALL be 1 only when LOCKED and H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACTIVE.
REQ-031 In that window, x SHALL equal hcnt-(H_SYNC+H_BP) and y SHALL equal vcnt-(V_SYNC+V_BP).
REQ-032 When de=0, x, y and rgb_out SHALL hold 0.
REQ-033 sof SHALL be 1 iff de=1 and x=0 and y=0.
REQ-034 If a vsync edge and an hsync edge fall in the same cycle, the hsync edge SHALL be evaluated first and then the frame check.
REQ-035 Counter saturation (no sync present) SHALL count as a bad line on the next edge.

Reset
REQ-036 While rst_n=0, the state SHALL be SEARCH; de, sof, locked and sync_err SHALL be 0; x, y and rgb_out SHALL be 0; and all counters and sync registers SHALL be 0.
REQ-037 Reset assertion SHALL take effect asynchronously, and release SHALL be sampled on pclk; after release, lock SHALL need a full reacquisition.

Structure
REQ-038 The 800x600@60 timing constants and the FSM state enum SHALL live in a shared package, vga_pkg, also used by vga_timing.
REQ-039 A sub-module, sync_edge, SHALL provide the 2-flop register and rising-edge pulse and SHALL be instantiated twice, once for hs and once for vs.

Verification
REQ-040 Drive the vga_timing output at default timing for 4 frames; locked SHALL rise after the 3rd vsync edge following reset (SEARCH, then 2 good frames), and no sync_err SHALL occur.
REQ-041 When locked, feed rgb_in = {x[3:0], y[3:0], 4'h5}; every de pixel SHALL match, de SHALL count 480000 per frame, and sof SHALL occur once per frame.
REQ-042 When locked, shorten one line to 1055 cycles; sync_err SHALL pulse once at that hsync edge, and locked SHALL fall and relock 2 frames later.
REQ-043 Stop hs_in while locked; sync_err SHALL pulse at the next hsync edge, and de SHALL stay 0 until relock.
REQ-044 Assert rst_n mid-line for 3 cycles; all outputs SHALL be 0 at once (asynchronous), and relock SHALL follow REQ-040 timing.
REQ-045 Apply vsync and hsync edges in the same cycle; the line SHALL be checked before the frame, and vcnt SHALL restart at 0.
